// File: rtl/psp_retmon_pkg.sv
// psp_retmon_pkg: shared status encoding, terminal error codes and popcount helper for the retire monitor.
package psp_retmon_pkg;
  typedef enum logic [2:0] {
    RUN          = 3'd0,
    PASS         = 3'd1,
    FAIL_ERR     = 3'd2,
    FAIL_TIMEOUT = 3'd3,
    FAIL_PC      = 3'd4
  } status_t;
  localparam logic [15:0] ERR_PC      = 16'hFFFF;
  localparam logic [15:0] ERR_TIMEOUT = 16'hFFFE;
  function automatic logic [2:0] popcount(input logic [3:0] v);
    popcount = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/psp_lane_prefix.sv
// psp_lane_prefix: exclusive prefix popcount of the lane valids (per-lane offset) plus the total count.
module psp_lane_prefix
  import psp_retmon_pkg::*;
#(
  parameter int NRET = 1
) (
  input  logic [NRET-1:0]   valid,
  output logic [NRET*3-1:0] offset,
  output logic [2:0]        total
);
  logic [3:0] vz;
  assign vz = 4'(valid);
  assign total = popcount(vz);
  for (genvar i = 0; i < NRET; i++) begin : g_off
    assign offset[i*3 +: 3] = popcount(vz & ((4'd1 << i) - 4'd1));
  end
endmodule

// File: rtl/psp_retire_monitor.sv
// psp_retire_monitor: RVFI retire order numbering, no-retire watchdog and sticky pass/fail status.
// Optional PC continuity check across retirements is enabled by defining PSP_RETMON_PC_CHECK_EN.
module psp_retire_monitor
  import psp_retmon_pkg::*;
#(
  parameter int NRET           = 1,
  parameter int ORDER_W        = 64,
  parameter int ERR_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*32-1:0]      rvfi_pc_rdata,
  input  logic [NRET*32-1:0]      rvfi_pc_wdata,
  input  logic [ERR_W-1:0]        errcode,
  input  logic                    done,
  output logic [NRET*ORDER_W-1:0] lane_order,
  output logic [ORDER_W-1:0]      retired,
  output status_t                 status,
  output logic                    halt,
  output logic [ERR_W-1:0]        err_code_q,
  output logic [ORDER_W-1:0]      err_order_q,
  output logic [1:0]              err_lane_q
);
  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [NRET*3-1:0]    offset;
  logic [2:0]           total;
  logic                 any_valid, timeout, pc_bad, fail_entry;
  logic [1:0]           bad_lane, lane_d;
  logic [TIMEOUT_W-1:0] wdog;
  logic [ERR_W-1:0]     code_d;
  status_t              next;
  psp_lane_prefix #(.NRET(NRET)) u_prefix (
    .valid (rvfi_valid),
    .offset(offset),
    .total (total)
  );
  for (genvar i = 0; i < NRET; i++) begin : g_order
    assign lane_order[i*ORDER_W +: ORDER_W] = retired + ORDER_W'(offset[i*3 +: 3]);
  end
  assign any_valid = |rvfi_valid;
  assign timeout = (TIMEOUT_CYCLES != 0) && !any_valid && (wdog == WD_LIMIT);
`ifdef PSP_RETMON_PC_CHECK_EN
  logic [31:0] last_pc, chain_pc;
  logic        last_pc_valid, chain_valid;
  // Each valid lane must continue from the previous valid lane, or from the last retired insn.
  always_comb begin
    chain_pc = last_pc;
    chain_valid = last_pc_valid;
    pc_bad = 1'b0;
    bad_lane = 2'd0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        if (chain_valid && !pc_bad && rvfi_pc_rdata[i*32 +: 32] != chain_pc) begin
          pc_bad = 1'b1;
          bad_lane = 2'(i);
        end
        chain_pc = rvfi_pc_wdata[i*32 +: 32];
        chain_valid = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc <= '0;
      last_pc_valid <= 1'b0;
    end else if (status == RUN) begin
      last_pc <= chain_pc;
      last_pc_valid <= chain_valid;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^{rvfi_pc_rdata, rvfi_pc_wdata};
  assign pc_bad = 1'b0;
  assign bad_lane = 2'd0;
`endif
  always_ff @(posedge clk) status <= reset ? RUN : next;
  always_comb begin
    next = status;
    if (status == RUN)
      next = errcode != '0 ? FAIL_ERR : pc_bad ? FAIL_PC : done ? PASS : timeout ? FAIL_TIMEOUT : RUN;
  end
  always_comb begin
    halt = status != RUN;
    fail_entry = status == RUN && next != RUN && next != PASS;
    code_d = next == FAIL_ERR ? errcode : next == FAIL_PC ? ERR_W'(ERR_PC) : ERR_W'(ERR_TIMEOUT);
    lane_d = next == FAIL_PC ? bad_lane : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
      wdog <= '0;
      err_code_q <= '0;
      err_order_q <= '0;
      err_lane_q <= '0;
    end else if (status == RUN) begin
      retired <= retired + ORDER_W'(total);
      wdog <= any_valid ? '0 : (&wdog ? wdog : wdog + TIMEOUT_W'(1));
      if (fail_entry) begin
        err_code_q <= code_d;
        err_order_q <= retired;
        err_lane_q <= lane_d;
      end
    end
  end
endmodule

// File: tb/tb_psp_retire_monitor.sv
// tb_psp_retire_monitor: scoreboard bench for psp_retire_monitor (NRET=2, ORDER_W=4, TIMEOUT_CYCLES=8).
module tb_psp_retire_monitor;
  import psp_retmon_pkg::*;
  localparam int NRET = 2, ORDER_W = 4, ERR_W = 16, TO = 8;
  logic clk = 1'b0, reset = 1'b1, done = 1'b0;
  logic [NRET-1:0] rvfi_valid = '0;
  logic [NRET*32-1:0] rvfi_pc_rdata = '0, rvfi_pc_wdata = '0;
  logic [ERR_W-1:0] errcode = '0, err_code_q;
  logic [NRET*ORDER_W-1:0] lane_order;
  logic [ORDER_W-1:0] retired, err_order_q;
  status_t status;
  logic halt;
  logic [1:0] err_lane_q;
  int n_checks = 0, n_fail = 0;
  logic [ORDER_W-1:0] m_ret;
  logic [ORDER_W-1:0] exp_q[$];

  psp_retire_monitor #(
    .NRET(NRET), .ORDER_W(ORDER_W), .ERR_W(ERR_W), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .errcode(errcode), .done(done), .lane_order(lane_order),
    .retired(retired), .status(status), .halt(halt), .err_code_q(err_code_q),
    .err_order_q(err_order_q), .err_lane_q(err_lane_q)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rvfi_valid = '0; errcode = '0; done = 1'b0;
    rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_ret = '0;
    exp_q.delete();
  endtask

  // One retire cycle: expected lane orders and next retired count go through the scoreboard queue.
  task automatic step(input logic [1:0] v, input logic [63:0] pcr, input logic [63:0] pcw);
    logic [ORDER_W-1:0] e;
    @(negedge clk);
    rvfi_valid = v; rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
    exp_q.push_back(m_ret);
    exp_q.push_back(m_ret + ORDER_W'(v[0]));
    #1;
    e = exp_q.pop_front();
    if (v[0]) begin
      n_checks++;
      if (lane_order[3:0] !== e) begin n_fail++; $display("FAIL lane_order0: got %0d expected %0d", lane_order[3:0], e); end
    end
    e = exp_q.pop_front();
    if (v[1]) begin
      n_checks++;
      if (lane_order[7:4] !== e) begin n_fail++; $display("FAIL lane_order1: got %0d expected %0d", lane_order[7:4], e); end
    end
    m_ret = m_ret + ORDER_W'(v[0]) + ORDER_W'(v[1]);
    exp_q.push_back(m_ret);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_checks++;
    if (retired !== e) begin n_fail++; $display("FAIL retired: got %0d expected %0d", retired, e); end
    rvfi_valid = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks += 6;
    if (retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    if (status !== RUN) begin n_fail++; $display("FAIL reset_status: got %0d expected 0", status); end
    if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %0b expected 0", halt); end
    if (err_code_q !== 16'h0) begin n_fail++; $display("FAIL reset_err_code: got %h expected 0", err_code_q); end
    if (err_order_q !== 4'd0) begin n_fail++; $display("FAIL reset_err_order: got %0d expected 0", err_order_q); end
    if (err_lane_q !== 2'd0) begin n_fail++; $display("FAIL reset_err_lane: got %0d expected 0", err_lane_q); end
  endtask

  task automatic test_order_burst();
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b11, '0, '0);
    step(2'b01, '0, '0);
    n_checks++;
    if (retired !== 4'd7) begin n_fail++; $display("FAIL burst_total: got %0d expected 7", retired); end
  endtask

  task automatic test_noncontig();
    do_reset();
    step(2'b10, '0, '0);
    step(2'b10, '0, '0);
    step(2'b11, '0, '0);
  endtask

  task automatic test_err_done();
    do_reset();
    step(2'b11, '0, '0); step(2'b11, '0, '0); step(2'b01, '0, '0);
    @(negedge clk);
    rvfi_valid = 2'b11; errcode = 16'h0042; done = 1'b1;
    #1;
    n_checks++;
    if (status !== RUN) begin n_fail++; $display("FAIL err_status_early: got %0d expected 0", status); end
    @(posedge clk); #1;
    n_checks += 5;
    if (status !== FAIL_ERR) begin n_fail++; $display("FAIL err_status: got %0d expected 2", status); end
    if (err_code_q !== 16'h0042) begin n_fail++; $display("FAIL err_code: got %h expected 0042", err_code_q); end
    if (err_order_q !== 4'd5) begin n_fail++; $display("FAIL err_order: got %0d expected 5", err_order_q); end
    if (halt !== 1'b1) begin n_fail++; $display("FAIL err_halt: got %0b expected 1", halt); end
    if (retired !== 4'd7) begin n_fail++; $display("FAIL err_retired: got %0d expected 7", retired); end
    errcode = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 3;
    if (status !== FAIL_ERR) begin n_fail++; $display("FAIL err_sticky: got %0d expected 2", status); end
    if (retired !== 4'd7) begin n_fail++; $display("FAIL err_frozen: got %0d expected 7", retired); end
    if (err_code_q !== 16'h0042) begin n_fail++; $display("FAIL err_code_hold: got %h expected 0042", err_code_q); end
    rvfi_valid = '0; done = 1'b0;
  endtask

  task automatic test_done();
    do_reset();
    step(2'b01, '0, '0);
    @(negedge clk); done = 1'b1;
    @(posedge clk); #1;
    n_checks += 3;
    if (status !== PASS) begin n_fail++; $display("FAIL done_status: got %0d expected 1", status); end
    if (halt !== 1'b1) begin n_fail++; $display("FAIL done_halt: got %0b expected 1", halt); end
    if (err_code_q !== 16'h0) begin n_fail++; $display("FAIL done_err_code: got %h expected 0", err_code_q); end
    done = 1'b0; errcode = 16'h0005;
    @(posedge clk); #1;
    n_checks += 2;
    if (status !== PASS) begin n_fail++; $display("FAIL done_sticky: got %0d expected 1", status); end
    if (err_code_q !== 16'h0) begin n_fail++; $display("FAIL done_ignore_err: got %h expected 0", err_code_q); end
    errcode = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (TO - 1) @(posedge clk);
    #1;
    n_checks++;
    if (status !== RUN) begin n_fail++; $display("FAIL to_early: got %0d expected 0", status); end
    @(posedge clk); #1;
    n_checks += 3;
    if (status !== FAIL_TIMEOUT) begin n_fail++; $display("FAIL to_status: got %0d expected 3", status); end
    if (err_code_q !== 16'hFFFE) begin n_fail++; $display("FAIL to_code: got %h expected fffe", err_code_q); end
    if (halt !== 1'b1) begin n_fail++; $display("FAIL to_halt: got %0b expected 1", halt); end
    do_reset();
    repeat (5) @(posedge clk);
    step(2'b01, '0, '0);
    repeat (TO - 1) @(posedge clk);
    #1;
    n_checks++;
    if (status !== RUN) begin n_fail++; $display("FAIL to_kick: got %0d expected 0", status); end
    @(posedge clk); #1;
    n_checks += 2;
    if (status !== FAIL_TIMEOUT) begin n_fail++; $display("FAIL to_after_kick: got %0d expected 3", status); end
    if (err_order_q !== 4'd1) begin n_fail++; $display("FAIL to_order: got %0d expected 1", err_order_q); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) step(2'b01, '0, '0);
    n_checks++;
    if (retired !== 4'd1) begin n_fail++; $display("FAIL wrap: got %0d expected 1", retired); end
    step(2'b01, '0, '0); step(2'b01, '0, '0);
    @(negedge clk);
    reset = 1'b1; rvfi_valid = 2'b01;
    @(posedge clk); #1;
    n_checks += 2;
    if (retired !== 4'd0) begin n_fail++; $display("FAIL midreset_retired: got %0d expected 0", retired); end
    if (status !== RUN) begin n_fail++; $display("FAIL midreset_status: got %0d expected 0", status); end
    reset = 1'b0; rvfi_valid = '0;
  endtask

  task automatic test_pc();
    do_reset();
    step(2'b01, {32'h0, 32'h0FC}, {32'h0, 32'h100});
    n_checks++;
    if (status !== RUN) begin n_fail++; $display("FAIL pc_first: got %0d expected 0", status); end
    step(2'b11, {32'h108, 32'h100}, {32'h10C, 32'h104});
`ifdef PSP_RETMON_PC_CHECK_EN
    n_checks += 4;
    if (status !== FAIL_PC) begin n_fail++; $display("FAIL pc_status: got %0d expected 4", status); end
    if (err_lane_q !== 2'd1) begin n_fail++; $display("FAIL pc_lane: got %0d expected 1", err_lane_q); end
    if (err_code_q !== 16'hFFFF) begin n_fail++; $display("FAIL pc_code: got %h expected ffff", err_code_q); end
    if (err_order_q !== 4'd1) begin n_fail++; $display("FAIL pc_order: got %0d expected 1", err_order_q); end
`else
    n_checks += 2;
    if (status !== RUN) begin n_fail++; $display("FAIL pc_ignored: got %0d expected 0", status); end
    if (err_lane_q !== 2'd0) begin n_fail++; $display("FAIL pc_lane_tied: got %0d expected 0", err_lane_q); end
`endif
  endtask

  initial begin
    test_reset();
    test_order_burst();
    test_noncontig();
    test_err_done();
    test_reset();
    test_done();
    test_timeout();
    test_wrap();
    test_pc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
